// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: valid/ready sequencer for a DEPTH-stage tap delay line with a one-shot window handshake.
// Define SHIFT_CHAIN_CTRL_FLUSH_EN to build the zero-injection flush; otherwise flush is ignored.
module shift_chain_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       shift_en,
  output logic [WIDTH-1:0]           shift_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  output logic                       busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] fill_nxt;
  logic          win_valid_nxt;
  logic          accept;
  logic          window_free;
  logic          flushing;

  // A new sample may only enter once the current window has been taken, so the MAC never sees it move.
  assign window_free = !win_valid || win_ready;

`ifdef SHIFT_CHAIN_CTRL_FLUSH_EN
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam int FW = $clog2(DEPTH);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(DEPTH-1);

  logic [FW-1:0] flush_cnt;
  logic [FW-1:0] flush_cnt_nxt;

  assign flushing = (state == ST_FLUSH);
  assign in_ready = rst_n && !flushing && !flush && window_free;
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign flushing     = 1'b0;
  assign in_ready     = rst_n && window_free;
`endif

  assign accept     = in_valid && in_ready;
  assign shift_en   = accept || flushing;
  assign shift_data = flushing ? '0 : in_data;
  assign busy       = flushing;

  always_comb begin
    state_nxt     = state;
    fill_nxt      = fill_count;
    win_valid_nxt = win_valid;
`ifdef SHIFT_CHAIN_CTRL_FLUSH_EN
    flush_cnt_nxt = flush_cnt;
    if (flushing) begin
      win_valid_nxt = 1'b0;
      if (flush_cnt == FLUSH_LAST) begin
        flush_cnt_nxt = '0;
        fill_nxt      = '0;
        state_nxt     = ST_FILL;
      end else begin
        flush_cnt_nxt = flush_cnt + 1'b1;
      end
    end else if (flush) begin
      // Any pending window is dropped; the line is about to be overwritten with zeros.
      state_nxt     = ST_FLUSH;
      flush_cnt_nxt = '0;
      win_valid_nxt = 1'b0;
    end else
`endif
    if (accept) begin
      if (state == ST_RUN) begin
        win_valid_nxt = 1'b1;
      end else begin
        fill_nxt = fill_count + 1'b1;
        if (fill_nxt == FULL) begin
          state_nxt     = ST_RUN;
          win_valid_nxt = 1'b1;
        end
      end
    end else if (win_valid && win_ready) begin
      win_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      fill_count <= '0;
      win_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      fill_count <= fill_nxt;
      win_valid  <= win_valid_nxt;
    end
  end

`ifdef SHIFT_CHAIN_CTRL_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else begin
      flush_cnt <= flush_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb_shift_chain_ctrl: drives shift_chain_ctrl with an external chain model; windows are scoreboarded.
// Flush scenarios follow SHIFT_CHAIN_CTRL_FLUSH_EN the same way the design does.
module tb_shift_chain_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int LW    = DEPTH*WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             flush = 1'b0;
  logic             win_ready = 1'b0;
  logic             in_ready;
  logic             shift_en;
  logic [WIDTH-1:0] shift_data;
  logic             win_valid;
  logic [CW-1:0]    fill_count;
  logic             busy;

  logic [LW-1:0] taps = '0;
  logic [LW-1:0] exp_line = '0;
  logic [LW-1:0] exp_win;
  logic [LW-1:0] win_q[$];
  int total = 0;
  int bad = 0;
  int windows = 0;

  always #5 clk = ~clk;

  shift_chain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .shift_en(shift_en), .shift_data(shift_data), .win_valid(win_valid),
    .win_ready(win_ready), .fill_count(fill_count), .busy(busy)
  );

  // Tap 0 (newest) sits in the top slice of taps.
  always @(posedge clk) begin
    if (shift_en) taps <= {shift_data, taps[LW-1:WIDTH]};
  end

  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready) begin
      windows++;
      total++;
      if (win_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL window_unexpected got=%h want=none", taps);
      end else begin
        exp_win = win_q.pop_front();
        if (taps !== exp_win) begin
          bad++;
          $display("[TB] FAIL window_taps got=%h want=%h", taps, exp_win);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; win_ready = 1'b0;
    win_q.delete();
    exp_line = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1; win_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({shift_en, win_valid, busy, fill_count} !== {3'b000, CW'(0)}) begin
      bad++;
      $display("[TB] FAIL reset_values got=%b want=%b", {shift_en, win_valid, busy, fill_count}, {3'b000, CW'(0)});
    end
    step();
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, shift_en, win_valid, busy, fill_count} !== {4'b1000, CW'(0)}) begin
      bad++;
      $display("[TB] FAIL reset_release got=%b want=%b", {in_ready, shift_en, win_valid, busy, fill_count}, {4'b1000, CW'(0)});
    end
  endtask

  task automatic test_fill();
    win_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      in_valid = 1'b1;
      in_data  = WIDTH'(i + 1);
      exp_line = {in_data, exp_line[LW-1:WIDTH]};
      if (i == DEPTH-1) win_q.push_back(exp_line);
      @(negedge clk);
      total++;
      if ({in_ready, shift_en, win_valid, fill_count, shift_data} !== {3'b110, CW'(i), in_data}) begin
        bad++;
        $display("[TB] FAIL fill_step%0d got=%h want=%h", i, {in_ready, shift_en, win_valid, fill_count, shift_data}, {3'b110, CW'(i), in_data});
      end
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({win_valid, fill_count, taps} !== {1'b1, CW'(DEPTH), 32'h04030201}) begin
      bad++;
      $display("[TB] FAIL fill_window got=%h want=%h", {win_valid, fill_count, taps}, {1'b1, CW'(DEPTH), 32'h04030201});
    end
    step();
    @(negedge clk);
    total++;
    if ({win_valid, fill_count} !== {1'b0, CW'(DEPTH)}) begin
      bad++;
      $display("[TB] FAIL fill_consumed got=%b want=%b", {win_valid, fill_count}, {1'b0, CW'(DEPTH)});
    end
  endtask

  task automatic test_backpressure();
    step();
    win_ready = 1'b0; in_valid = 1'b1; in_data = 8'd5;
    exp_line = {in_data, exp_line[LW-1:WIDTH]};
    win_q.push_back(exp_line);
    @(negedge clk);
    total++;
    if ({in_ready, shift_en, win_valid} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL bp_accept got=%b want=110", {in_ready, shift_en, win_valid});
    end
    for (int c = 0; c < 2; c++) begin
      step();
      in_data = 8'd6;
      @(negedge clk);
      total++;
      if ({in_ready, shift_en, win_valid, fill_count} !== {3'b001, CW'(DEPTH)}) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d got=%b want=%b", c, {in_ready, shift_en, win_valid, fill_count}, {3'b001, CW'(DEPTH)});
      end
    end
    step();
    win_ready = 1'b1;
    exp_line = {in_data, exp_line[LW-1:WIDTH]};
    win_q.push_back(exp_line);
    @(negedge clk);
    total++;
    if ({in_ready, shift_en, win_valid, shift_data} !== {3'b111, 8'd6}) begin
      bad++;
      $display("[TB] FAIL bp_release got=%h want=%h", {in_ready, shift_en, win_valid, shift_data}, {3'b111, 8'd6});
    end
    step();
    win_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (win_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_new_window got=%b want=1", win_valid);
    end
    step();
    win_ready = 1'b1;
    step();
    @(negedge clk);
    total++;
    if ({win_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL bp_drained got=%b want=01", {win_valid, in_ready});
    end
  endtask

  task automatic test_back_to_back();
    int start;
    reset_dut();
    start = windows;
    win_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(100 + k);
      exp_line = {in_data, exp_line[LW-1:WIDTH]};
      if (k >= DEPTH-1) win_q.push_back(exp_line);
      @(negedge clk);
      total++;
      if ({in_ready, shift_en, win_valid} !== {2'b11, (k >= DEPTH)}) begin
        bad++;
        $display("[TB] FAIL stream%0d got=%b want=%b", k, {in_ready, shift_en, win_valid}, {2'b11, (k >= DEPTH)});
      end
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    total++;
    if ((windows - start) !== 17 || win_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL stream_count got=%0d want=17 (left=%0d)", windows - start, win_q.size());
    end
  endtask

`ifdef SHIFT_CHAIN_CTRL_FLUSH_EN
  task automatic test_flush();
    win_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    total++;
    if ({in_ready, shift_en} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL flush_pre got=%b want=11", {in_ready, shift_en});
    end
    step();
    flush = 1'b1; in_data = 8'h88;
    @(negedge clk);
    total++;
    if ({in_ready, shift_en, win_valid, busy} !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL flush_conflict got=%b want=0010", {in_ready, shift_en, win_valid, busy});
    end
    for (int j = 0; j < DEPTH; j++) begin
      step();
      flush = (j == 1);
      @(negedge clk);
      total++;
      if ({in_ready, shift_en, shift_data, win_valid, busy, fill_count} !== {2'b01, 8'h00, 2'b01, CW'(DEPTH)}) begin
        bad++;
        $display("[TB] FAIL flush_cycle%0d got=%h want=%h", j, {in_ready, shift_en, shift_data, win_valid, busy, fill_count}, {2'b01, 8'h00, 2'b01, CW'(DEPTH)});
      end
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    exp_line = '0;
    @(negedge clk);
    total++;
    if ({in_ready, busy, win_valid, fill_count, taps} !== {3'b100, CW'(0), exp_line}) begin
      bad++;
      $display("[TB] FAIL flush_done got=%h want=%h", {in_ready, busy, win_valid, fill_count, taps}, {3'b100, CW'(0), exp_line});
    end
    win_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(8'h21 + i);
      exp_line = {in_data, exp_line[LW-1:WIDTH]};
      if (i == DEPTH-1) win_q.push_back(exp_line);
      @(negedge clk);
      total++;
      if ({shift_en, win_valid, fill_count} !== {2'b10, CW'(i)}) begin
        bad++;
        $display("[TB] FAIL refill%0d got=%b want=%b", i, {shift_en, win_valid, fill_count}, {2'b10, CW'(i)});
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (win_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL refill_window got=%b want=1", win_valid);
    end
    step();
  endtask
`else
  task automatic test_flush();
    win_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    exp_line = {in_data, exp_line[LW-1:WIDTH]};
    win_q.push_back(exp_line);
    @(negedge clk);
    total++;
    if ({in_ready, shift_en, busy, shift_data} !== {3'b110, 8'h55}) begin
      bad++;
      $display("[TB] FAIL flush_ignored got=%h want=%h", {in_ready, shift_en, busy, shift_data}, {3'b110, 8'h55});
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({win_valid, busy, fill_count} !== {2'b10, CW'(DEPTH)}) begin
      bad++;
      $display("[TB] FAIL flush_no_clear got=%b want=%b", {win_valid, busy, fill_count}, {2'b10, CW'(DEPTH)});
    end
    step();
    flush = 1'b0;
  endtask
`endif

  task automatic test_reset_midway();
    win_ready = 1'b0;
`ifdef SHIFT_CHAIN_CTRL_FLUSH_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
`else
    in_valid = 1'b1; in_data = 8'h66;
    step();
`endif
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({shift_en, win_valid, busy, fill_count} !== {3'b000, CW'(0)}) begin
      bad++;
      $display("[TB] FAIL reset_async got=%b want=%b", {shift_en, win_valid, busy, fill_count}, {3'b000, CW'(0)});
    end
    step();
    @(negedge clk);
    total++;
    if ({shift_en, win_valid, busy, fill_count} !== {3'b000, CW'(0)}) begin
      bad++;
      $display("[TB] FAIL reset_hold got=%b want=%b", {shift_en, win_valid, busy, fill_count}, {3'b000, CW'(0)});
    end
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, shift_en, busy} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL reset_exit got=%b want=100", {in_ready, shift_en, busy});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midway();
    total++;
    if (win_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL windows_left got=%0d want=0", win_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
